rv32_dec_stage: RTL and testbench

//  Second-generation RV32 decode stage between IFU and EXE, with valid/ready handshakes on both sides.

---
 rtl/rv32_pkg.sv | 83 ++++++++
 rtl/rv32_regfile.sv | 59 +++++
 rtl/rv32_dec_stage.sv | 178 +++++++++++++++++
 tb/tb_rv32_dec_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 decode definitions: base opcodes, immediate formats and the per-opcode
// decode record used by the decode stage.
package rv32_pkg;

    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcFence  = 7'b0001111;
    localparam logic [6:0] OpcSystem = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_SHAMT
    } imm_fmt_e;

    typedef struct packed {
        logic     use_rs1;
        logic     use_rs2;
        logic     use_rd;
        imm_fmt_e fmt;
        logic     illegal;
    } dec_t;

    // Opcode-level decode only; register-index legality is checked by the stage.
    function automatic dec_t decode_opcode(input logic [6:0] opc, input logic [2:0] funct3);
        dec_t d;
        d.use_rs1 = 1'b0;
        d.use_rs2 = 1'b0;
        d.use_rd  = 1'b0;
        d.fmt     = IMM_NONE;
        d.illegal = 1'b0;
        case (opc)
            OpcLui, OpcAuipc: begin
                d.use_rd = 1'b1;
                d.fmt    = IMM_U;
            end
            OpcJal: begin
                d.use_rd = 1'b1;
                d.fmt    = IMM_J;
            end
            OpcJalr, OpcLoad: begin
                d.use_rs1 = 1'b1;
                d.use_rd  = 1'b1;
                d.fmt     = IMM_I;
            end
            OpcBranch: begin
                d.use_rs1 = 1'b1;
                d.use_rs2 = 1'b1;
                d.fmt     = IMM_B;
            end
            OpcStore: begin
                d.use_rs1 = 1'b1;
                d.use_rs2 = 1'b1;
                d.fmt     = IMM_S;
            end
            OpcOpImm: begin
                d.use_rs1 = 1'b1;
                d.use_rd  = 1'b1;
                d.fmt     = (funct3[1:0] == 2'b01) ? IMM_SHAMT : IMM_I;
            end
            OpcOp: begin
                d.use_rs1 = 1'b1;
                d.use_rs2 = 1'b1;
                d.use_rd  = 1'b1;
            end
            OpcFence, OpcSystem: d.fmt = IMM_I;
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/rv32_regfile.sv
// Integer register file: NREG x XLEN, two combinational read ports, one write port,
// optional write-through so a same-cycle write is visible on the read ports.
module rv32_regfile #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      raddr_a_i,
    output logic [XLEN-1:0] rdata_a_o,
    input  logic [4:0]      raddr_b_i,
    output logic [XLEN-1:0] rdata_b_o,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;

    logic [XLEN-1:0] mem_q [NREG];
    logic            wr_en;

    // x0 and out-of-range indices are never written.
    assign wr_en = we_i && (waddr_i != 5'd0) && (32'(waddr_i) < NREG);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[waddr_i[AW-1:0]] <= wdata_i;
        end
    end

    always_comb begin
        rdata_a_o = '0;
        if (raddr_a_i != 5'd0 && 32'(raddr_a_i) < NREG) begin
            if (BYPASS != 0 && wr_en && waddr_i == raddr_a_i) begin
                rdata_a_o = wdata_i;
            end else begin
                rdata_a_o = mem_q[raddr_a_i[AW-1:0]];
            end
        end
    end

    always_comb begin
        rdata_b_o = '0;
        if (raddr_b_i != 5'd0 && 32'(raddr_b_i) < NREG) begin
            if (BYPASS != 0 && wr_en && waddr_i == raddr_b_i) begin
                rdata_b_o = wdata_i;
            end else begin
                rdata_b_o = mem_q[raddr_b_i[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/rv32_dec_stage.sv
// RV32 decode stage: decodes one instruction per cycle into a registered EXE bundle, reads
// operands, and stalls on pending-register hazards tracked by a scoreboard.
module rv32_dec_stage
    import rv32_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NREG      = 32,
    parameter int unsigned WB_BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     in_instr_i,
    input  logic [XLEN-1:0] in_pc_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [10:0]     out_op_o,
    output logic [XLEN-1:0] out_rs1_val_o,
    output logic [XLEN-1:0] out_rs2_val_o,
    output logic [XLEN-1:0] out_imm_o,
    output logic [4:0]      out_rd_o,
    output logic [XLEN-1:0] out_pc_o,
    output logic            out_illegal_o,
    input  logic            wb_valid_i,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i
);

    logic [6:0]      opc;
    logic [2:0]      funct3;
    logic [4:0]      rs1, rs2, rd_raw, rd_eff;
    dec_t            dec;
    logic            illegal;
    logic [31:0]     imm;
    logic [XLEN-1:0] rf_rs1, rf_rs2;
    logic            clr_rs1, clr_rs2, hazard, accept;

    logic [31:0]     pend_q, pend_d;
    logic            out_valid_q, out_valid_d;
    logic [10:0]     out_op_q, out_op_d;
    logic [XLEN-1:0] out_rs1_val_q, out_rs1_val_d;
    logic [XLEN-1:0] out_rs2_val_q, out_rs2_val_d;
    logic [XLEN-1:0] out_imm_q, out_imm_d;
    logic [4:0]      out_rd_q, out_rd_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic            out_illegal_q, out_illegal_d;

    assign opc    = in_instr_i[6:0];
    assign funct3 = in_instr_i[14:12];
    assign rd_raw = in_instr_i[11:7];
    assign rs1    = in_instr_i[19:15];
    assign rs2    = in_instr_i[24:20];
    assign dec    = decode_opcode(opc, funct3);

    assign illegal = dec.illegal
                   | (dec.use_rs1 && 32'(rs1) >= NREG)
                   | (dec.use_rs2 && 32'(rs2) >= NREG)
                   | (dec.use_rd  && 32'(rd_raw) >= NREG);
    assign rd_eff  = (dec.use_rd && !illegal) ? rd_raw : 5'd0;

    rv32_regfile #(
        .XLEN   (XLEN),
        .NREG   (NREG),
        .BYPASS (WB_BYPASS)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .raddr_a_i (rs1),
        .rdata_a_o (rf_rs1),
        .raddr_b_i (rs2),
        .rdata_b_o (rf_rs2),
        .we_i      (wb_valid_i & wb_we_i),
        .waddr_i   (wb_rd_i),
        .wdata_i   (wb_data_i)
    );

    // A retiring write-back releases a waiting source in the same cycle; rd still waits.
    assign clr_rs1 = (WB_BYPASS != 0) && wb_valid_i && (wb_rd_i == rs1);
    assign clr_rs2 = (WB_BYPASS != 0) && wb_valid_i && (wb_rd_i == rs2);
    assign hazard  = (dec.use_rs1 && pend_q[rs1] && !clr_rs1)
                   | (dec.use_rs2 && pend_q[rs2] && !clr_rs2)
                   | pend_q[rd_eff];

    assign in_ready_o = rst_n & (flush_i | ((!out_valid_q | out_ready_i) & !hazard));
    assign accept     = in_valid_i & in_ready_o & !flush_i;

    always_comb begin
        imm = '0;
        unique case (dec.fmt)
            IMM_I:     imm = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
            IMM_S:     imm = {{20{in_instr_i[31]}}, in_instr_i[31:25], in_instr_i[11:7]};
            IMM_B:     imm = {{19{in_instr_i[31]}}, in_instr_i[31], in_instr_i[7],
                              in_instr_i[30:25], in_instr_i[11:8], 1'b0};
            IMM_U:     imm = {in_instr_i[31:12], 12'b0};
            IMM_J:     imm = {{11{in_instr_i[31]}}, in_instr_i[31], in_instr_i[19:12],
                              in_instr_i[20], in_instr_i[30:21], 1'b0};
            IMM_SHAMT: imm = {27'b0, in_instr_i[24:20]};
            default:   imm = '0;
        endcase
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        out_op_d      = out_op_q;
        out_rs1_val_d = out_rs1_val_q;
        out_rs2_val_d = out_rs2_val_q;
        out_imm_d     = out_imm_q;
        out_rd_d      = out_rd_q;
        out_pc_d      = out_pc_q;
        out_illegal_d = out_illegal_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d   = 1'b1;
            out_op_d      = {in_instr_i[30] & ((opc == OpcOp) |
                             ((opc == OpcOpImm) & (funct3 == 3'b101))), funct3, opc};
            out_rs1_val_d = dec.use_rs1 ? rf_rs1 : '0;
            out_rs2_val_d = dec.use_rs2 ? rf_rs2 : '0;
            out_imm_d     = XLEN'(imm);
            out_rd_d      = rd_eff;
            out_pc_d      = in_pc_i;
            out_illegal_d = illegal;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        pend_d = pend_q;
        if (wb_valid_i) begin
            pend_d[wb_rd_i] = 1'b0;
        end
        if (flush_i && out_valid_q) begin
            pend_d[out_rd_q] = 1'b0;
        end
        if (accept) begin
            pend_d[rd_eff] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q        <= '0;
            out_valid_q   <= 1'b0;
            out_op_q      <= '0;
            out_rs1_val_q <= '0;
            out_rs2_val_q <= '0;
            out_imm_q     <= '0;
            out_rd_q      <= '0;
            out_pc_q      <= '0;
            out_illegal_q <= 1'b0;
        end else begin
            pend_q        <= pend_d;
            out_valid_q   <= out_valid_d;
            out_op_q      <= out_op_d;
            out_rs1_val_q <= out_rs1_val_d;
            out_rs2_val_q <= out_rs2_val_d;
            out_imm_q     <= out_imm_d;
            out_rd_q      <= out_rd_d;
            out_pc_q      <= out_pc_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    assign out_valid_o   = out_valid_q;
    assign out_op_o      = out_op_q;
    assign out_rs1_val_o = out_rs1_val_q;
    assign out_rs2_val_o = out_rs2_val_q;
    assign out_imm_o     = out_imm_q;
    assign out_rd_o      = out_rd_q;
    assign out_pc_o      = out_pc_q;
    assign out_illegal_o = out_illegal_q;

endmodule

// File: tb/tb_rv32_dec_stage.sv
// Directed bench for rv32_dec_stage: an RV32I instance for handshake, hazard, flush and
// immediate cases, plus an RV32E instance for register-range legality.
module tb_rv32_dec_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr, in_pc;
    logic [10:0] out_op;
    logic [31:0] out_rs1_val, out_rs2_val, out_imm, out_pc;
    logic [4:0]  out_rd;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic        e_in_valid, e_in_ready, e_out_valid, e_out_illegal;
    logic [31:0] e_in_instr;
    logic [10:0] e_out_op;
    logic [31:0] e_rs1_val, e_rs2_val, e_imm, e_pc;
    logic [4:0]  e_rd;

    int checks   = 0;
    int failures = 0;
    int collide  = 0;

    always #5 clk = ~clk;

    rv32_dec_stage #(.XLEN(32), .NREG(32), .WB_BYPASS(1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_instr_i    (in_instr),
        .in_pc_i       (in_pc),
        .flush_i       (flush),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_op_o      (out_op),
        .out_rs1_val_o (out_rs1_val),
        .out_rs2_val_o (out_rs2_val),
        .out_imm_o     (out_imm),
        .out_rd_o      (out_rd),
        .out_pc_o      (out_pc),
        .out_illegal_o (out_illegal),
        .wb_valid_i    (wb_valid),
        .wb_we_i       (wb_we),
        .wb_rd_i       (wb_rd),
        .wb_data_i     (wb_data)
    );

    rv32_dec_stage #(.XLEN(32), .NREG(16), .WB_BYPASS(1)) dut_e (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid_i    (e_in_valid),
        .in_ready_o    (e_in_ready),
        .in_instr_i    (e_in_instr),
        .in_pc_i       (32'h0),
        .flush_i       (1'b0),
        .out_valid_o   (e_out_valid),
        .out_ready_i   (1'b1),
        .out_op_o      (e_out_op),
        .out_rs1_val_o (e_rs1_val),
        .out_rs2_val_o (e_rs2_val),
        .out_imm_o     (e_imm),
        .out_rd_o      (e_rd),
        .out_pc_o      (e_pc),
        .out_illegal_o (e_out_illegal),
        .wb_valid_i    (1'b0),
        .wb_we_i       (1'b0),
        .wb_rd_i       (5'd0),
        .wb_data_i     (32'h0)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] rd_of(input logic [31:0] ins);
        case (ins[6:0])
            7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33: return ins[11:7];
            default: return 5'd0;
        endcase
    endfunction

    // An accept that sets the same index a write-back clears would be a scoreboard race.
    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready && !flush && wb_valid &&
            rd_of(in_instr) != 5'd0 && rd_of(in_instr) == wb_rd) begin
            collide++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        @(negedge clk);
        check_eq("issue_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; in_instr = 32'h0; in_pc = 32'h0; flush = 1'b0;
        out_ready = 1'b1; wb_valid = 1'b0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
        e_in_valid = 1'b0; e_in_instr = 32'h0;
        repeat (2) cyc();
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_imm", out_imm, 0);
        check_eq("rst_out_pc", out_pc, 0);
        check_eq("rst_out_rd", out_rd, 0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        cyc();

        // 1: ADDI x1,x0,-5
        issue(32'hFFB00093, 32'h100);
        check_eq("t1_valid", out_valid, 1);
        check_eq("t1_imm", out_imm, 32'hFFFFFFFB);
        check_eq("t1_rd", out_rd, 1);
        check_eq("t1_op", out_op, 11'h013);
        check_eq("t1_pc", out_pc, 32'h100);
        check_eq("t1_pend1", dut.pend_q[1], 1);

        // 2: ADD x2,x1,x1 stalls on x1 until its write-back bypasses in
        in_valid = 1'b1; in_instr = 32'h00108133; in_pc = 32'h104;
        @(negedge clk);
        check_eq("t2_raw_stall", in_ready, 0);
        cyc();
        check_eq("t2_drained", out_valid, 0);
        wb_valid = 1'b1; wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'd7;
        @(negedge clk);
        check_eq("t2_bypass_ready", in_ready, 1);
        cyc();
        wb_valid = 1'b0; wb_we = 1'b0; in_valid = 1'b0;
        check_eq("t2_valid", out_valid, 1);
        check_eq("t2_rs1", out_rs1_val, 7);
        check_eq("t2_rs2", out_rs2_val, 7);
        check_eq("t2_rd", out_rd, 2);
        check_eq("t2_op", out_op, 11'h033);

        // 3: backpressure, then back-to-back stream
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100193; in_pc = 32'h108;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t3_hold_ready", in_ready, 0);
            check_eq("t3_hold_rd", out_rd, 2);
            check_eq("t3_hold_rs1", out_rs1_val, 7);
            cyc();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("t3_release_ready", in_ready, 1);
        cyc();
        in_instr = 32'h00200213; in_pc = 32'h10C;
        check_eq("t3_x3_rd", out_rd, 3);
        check_eq("t3_x3_imm", out_imm, 1);
        check_eq("t3_x3_pc", out_pc, 32'h108);
        cyc();
        in_instr = 32'h00300313; in_pc = 32'h110;
        check_eq("t3_x4_rd", out_rd, 4);
        check_eq("t3_x4_imm", out_imm, 2);
        cyc();
        in_valid = 1'b0;
        check_eq("t3_x6_rd", out_rd, 6);
        check_eq("t3_x6_pc", out_pc, 32'h110);
        cyc();
        check_eq("t3_empty", out_valid, 0);

        // 4: flush kills ADDI x5 in the output register and drops ADDI x7 at the input
        issue(32'h00900293, 32'h200);
        check_eq("t4_x5_valid", out_valid, 1);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00100393; in_pc = 32'h204;
        @(negedge clk);
        check_eq("t4_flush_ready", in_ready, 1);
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        check_eq("t4_killed", out_valid, 0);
        check_eq("t4_pend5", dut.pend_q[5], 0);
        check_eq("t4_pend7", dut.pend_q[7], 0);
        issue(32'h00028433, 32'h208);
        check_eq("t4_x8_rd", out_rd, 8);
        check_eq("t4_x8_rs1", out_rs1_val, 0);

        // 5: immediate formats
        issue(32'hFE000EE3, 32'h300);
        check_eq("t5_beq_imm", out_imm, 32'hFFFFFFFC);
        check_eq("t5_beq_rd", out_rd, 0);
        check_eq("t5_beq_op", out_op, 11'h063);
        issue(32'h001000EF, 32'h304);
        check_eq("t5_jal_imm", out_imm, 32'h00000800);
        check_eq("t5_jal_rd", out_rd, 1);
        issue(32'h123454B7, 32'h308);
        check_eq("t5_lui_imm", out_imm, 32'h12345000);
        issue(32'hFE002C23, 32'h30C);
        check_eq("t5_sw_imm", out_imm, 32'hFFFFFFF8);
        check_eq("t5_sw_rd", out_rd, 0);
        issue(32'h40505513, 32'h310);
        check_eq("t5_srai_imm", out_imm, 5);
        check_eq("t5_srai_op", out_op, 11'h693);

        // rd hazard is not relieved by a same-cycle write-back of that rd
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h314;
        wb_valid = 1'b1; wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h55;
        @(negedge clk);
        check_eq("t5_waw_stall", in_ready, 0);
        cyc();
        wb_valid = 1'b0; wb_we = 1'b0;
        @(negedge clk);
        check_eq("t5_waw_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        check_eq("t5_waw_rd", out_rd, 1);
        check_eq("t5_waw_imm", out_imm, 1);

        // 6: x0 write ignored (also on the bypass path), unknown opcode, RV32E range
        wb_valid = 1'b1; wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEADBEEF;
        issue(32'h000005B3, 32'h400);
        wb_valid = 1'b0; wb_we = 1'b0;
        check_eq("t6_x0_bypass", out_rs1_val, 0);
        issue(32'h00000633, 32'h404);
        check_eq("t6_x0_read", out_rs1_val, 0);
        check_eq("t6_add_legal", out_illegal, 0);
        issue(32'h0000007F, 32'h408);
        check_eq("t6_opc_illegal", out_illegal, 1);
        check_eq("t6_opc_rd", out_rd, 0);

        e_in_valid = 1'b1; e_in_instr = 32'h002088B3;
        @(negedge clk);
        check_eq("t6e_ready", e_in_ready, 1);
        cyc();
        e_in_instr = 32'hFFB00093;
        check_eq("t6e_x17_valid", e_out_valid, 1);
        check_eq("t6e_x17_illegal", e_out_illegal, 1);
        check_eq("t6e_x17_rd", e_rd, 0);
        cyc();
        e_in_valid = 1'b0;
        check_eq("t6e_x1_illegal", e_out_illegal, 0);
        check_eq("t6e_x1_rd", e_rd, 1);

        check_eq("no_set_clr_race", collide, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
